// File: rtl/dsp_alu_pkg.sv
// Shared types and helpers for the SIMD add/sub/accumulate pipeline.
package dsp_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ACC  = 2'd2,
        OP_LOAD = 2'd3
    } op_t;

    localparam int MAX_WIDTH = 48;

    // The guard only keeps elaboration alive long enough for the parameter check to report.
    function automatic int lane_width(input int width, input int lanes);
        return (lanes > 0) ? width / lanes : width;
    endfunction

endpackage

// File: rtl/dsp_alu_lane.sv
// One SIMD lane: wrap-around add/sub/accumulate/load with signed overflow flag.
module dsp_alu_lane
    import dsp_alu_pkg::*;
#(
    parameter int LW = 48
) (
    input  op_t           op_i,
    input  logic [LW-1:0] a_i,
    input  logic [LW-1:0] b_i,
    input  logic [LW-1:0] acc_i,
    output logic [LW-1:0] r_o,
    output logic          ovf_o
);

    always_comb begin
        r_o   = '0;
        ovf_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                r_o   = a_i + b_i;
                ovf_o = (a_i[LW-1] == b_i[LW-1]) && (r_o[LW-1] != a_i[LW-1]);
            end
            OP_SUB: begin
                r_o   = a_i - b_i;
                ovf_o = (a_i[LW-1] != b_i[LW-1]) && (r_o[LW-1] != a_i[LW-1]);
            end
            OP_ACC: begin
                r_o   = acc_i + a_i;
                ovf_o = (acc_i[LW-1] == a_i[LW-1]) && (r_o[LW-1] != a_i[LW-1]);
            end
            default: begin
                r_o   = a_i;
                ovf_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dsp_alu_pipe.sv
// Pipelined SIMD add/sub/accumulate unit with fixed latency and a global stall on backpressure.
module dsp_alu_pipe
    import dsp_alu_pkg::*;
#(
    parameter int WIDTH  = 48,
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [LANES-1:0] ovf
);

    localparam int LW = lane_width(WIDTH, LANES);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH || (LANES != 1 && LANES != 2 && LANES != 4) ||
        (WIDTH % LANES) != 0 || STAGES < 1 || STAGES > 3) begin : g_bad_param
        $error("dsp_alu_pipe: illegal WIDTH/LANES/STAGES combination");
    end

    op_t                           op_s;
    logic                          adv;
    logic                          accept;
    logic                          acc_wr;
    logic [LANES-1:0][LW-1:0]      r_d;
    logic [LANES-1:0]              ovf_d;
    logic [LANES-1:0][LW-1:0]      acc_q;
    logic [STAGES:1]               vld_pipe;
    logic [STAGES:1][WIDTH-1:0]    r_q;
    logic [STAGES:1][LANES-1:0]    ovf_q;

    assign op_s     = op_t'(op);
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign acc_wr   = accept && (op_s == OP_ACC || op_s == OP_LOAD);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dsp_alu_lane #(.LW(LW)) u_lane (
            .op_i  (op_s),
            .a_i   (a[k*LW +: LW]),
            .b_i   (b[k*LW +: LW]),
            .acc_i (acc_q[k]),
            .r_o   (r_d[k]),
            .ovf_o (ovf_d[k])
        );
    end

    // Data registers load only behind a valid beat, so y/ovf hold across bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            r_q      <= '0;
            ovf_q    <= '0;
            acc_q    <= '0;
        end else if (adv) begin
            vld_pipe[1] <= accept;
            if (accept) begin
                r_q[1]   <= r_d;
                ovf_q[1] <= ovf_d;
            end
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) begin
                    r_q[s]   <= r_q[s-1];
                    ovf_q[s] <= ovf_q[s-1];
                end
            end
            // ACC and LOAD both leave the lane result as the new accumulator value.
            if (acc_wr) acc_q <= r_d;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign y         = r_q[STAGES];
    assign ovf       = ovf_q[STAGES];

endmodule

// File: tb/tb_dsp_alu_pipe.sv
// Bench for dsp_alu_pipe: a 1-lane/2-stage and a 4-lane/3-stage instance against a beat-level model.
module tb_dsp_alu_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  in_valid = '0;
    logic [1:0]  out_ready = '1;
    logic [1:0]  op [2];
    logic [47:0] a [2];
    logic [47:0] b [2];
    logic        irdy0, irdy1, ovld0, ovld1;
    logic [47:0] y0, y1;
    logic [0:0]  ovf0;
    logic [3:0]  ovf1;

    wire  [1:0]  in_ready  = {irdy1, irdy0};
    wire  [1:0]  out_valid = {ovld1, ovld0};
    wire  [47:0] y_w [2];
    wire  [3:0]  ov_w [2];
    assign y_w[0]  = y0;
    assign y_w[1]  = y1;
    assign ov_w[0] = {3'b000, ovf0};
    assign ov_w[1] = ovf1;

    always #5 clock = ~clock;

    dsp_alu_pipe #(.WIDTH(48), .LANES(1), .STAGES(2)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(irdy0),
        .op(op[0]), .a(a[0]), .b(b[0]), .out_valid(ovld0), .out_ready(out_ready[0]),
        .y(y0), .ovf(ovf0)
    );

    dsp_alu_pipe #(.WIDTH(48), .LANES(4), .STAGES(3)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(irdy1),
        .op(op[1]), .a(a[1]), .b(b[1]), .out_valid(ovld1), .out_ready(out_ready[1]),
        .y(y1), .ovf(ovf1)
    );

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int rmode = 0;
    int ph = 0;

    logic [51:0] expq [2][$];
    logic [51:0] gotq [2][$];
    int          gotc [2][$];
    logic [47:0] acc_m [2];
    logic [51:0] prev_out [2];
    logic        prev_stall [2];
    logic        have_prev [2];
    int          hold_bad [2] = '{0, 0};
    int          rdy_bad [2] = '{0, 0};
    logic [47:0] m_y, m_acc;
    logic [3:0]  m_o;
    logic [51:0] cur;

    function automatic int lanes_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int stages_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic longint lane_val(input logic [47:0] v, input int k, input int lw);
        longint m, x;
        m = longint'(1) << lw;
        x = longint'(v >> (k * lw)) & (m - 1);
        return (x >= m / 2) ? x - m : x;
    endfunction

    // Signed integer arithmetic per lane; overflow is "true result outside the lane's range".
    function automatic void ref_beat(input int lanes, input logic [1:0] o,
                                     input logic [47:0] av, input logic [47:0] bv,
                                     input logic [47:0] accv, output logic [47:0] yv,
                                     output logic [3:0] ov, output logic [47:0] acc_n);
        int lw;
        longint m, sa, sb, sc, res, w;
        lw = 48 / lanes;
        m = longint'(1) << lw;
        yv = '0;
        ov = '0;
        acc_n = accv;
        for (int k = 0; k < lanes; k++) begin
            sa = lane_val(av, k, lw);
            sb = lane_val(bv, k, lw);
            sc = lane_val(accv, k, lw);
            case (o)
                2'd0:    res = sa + sb;
                2'd1:    res = sa - sb;
                2'd2:    res = sc + sa;
                default: res = sa;
            endcase
            ov[k] = (res >= m / 2) || (res < -(m / 2));
            w = ((res % m) + m) % m;
            yv = yv | (48'(w) << (k * lw));
            if (o >= 2'd2)
                acc_n = (acc_n & ~(48'(m - 1) << (k * lw))) | (48'(w) << (k * lw));
        end
    endfunction

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        if (rmode == 1) begin
            out_ready = {2{ph == 0 || ph == 3}};
            ph = (ph + 1) % 4;
        end else if (rmode == 2) begin
            out_ready = 2'($urandom_range(0, 3));
        end
    end

    // Records accepted beats (through the model) and delivered results; tasks do the comparing.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                acc_m[d] = '0;
                expq[d].delete();
                gotq[d].delete();
                gotc[d].delete();
                have_prev[d] = 1'b0;
            end else begin
                cur = {ov_w[d], y_w[d]};
                if (in_valid[d] && in_ready[d]) begin
                    ref_beat(lanes_of(d), op[d], a[d], b[d], acc_m[d], m_y, m_o, m_acc);
                    acc_m[d] = m_acc;
                    expq[d].push_back({m_o, m_y});
                end
                if (out_valid[d] && out_ready[d]) begin
                    gotq[d].push_back(cur);
                    gotc[d].push_back(cyc);
                end
                if (in_ready[d] !== !(out_valid[d] && !out_ready[d])) rdy_bad[d]++;
                if (have_prev[d]) begin
                    if (prev_stall[d] && (out_valid[d] !== 1'b1 || cur !== prev_out[d])) hold_bad[d]++;
                    if (!out_valid[d] && cur !== prev_out[d]) hold_bad[d]++;
                end
                prev_out[d]   = cur;
                prev_stall[d] = out_valid[d] && !out_ready[d];
                have_prev[d]  = 1'b1;
            end
        end
    end

    task automatic send(input int d, input logic [1:0] o, input logic [47:0] av, input logic [47:0] bv);
        int  n;
        bit  taken;
        n = 0;
        taken = 1'b0;
        in_valid[d] = 1'b1;
        op[d] = o;
        a[d] = av;
        b[d] = bv;
        while (!taken && n < 200) begin
            @(negedge clock);
            taken = in_ready[d];
            @(posedge clock);
            #1;
            n++;
        end
        vectors++;
        if (taken !== 1'b1) begin
            errs++;
            $display("FAIL send_timeout dut%0d: in_ready=%b after %0d cycles, required 1", d, in_ready[d], n);
        end
    endtask

    task automatic drain(input int d, output bit ok);
        int n;
        rmode = 0;
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            @(negedge clock);
            #1;
            ok = !out_valid[d] && (expq[d].size() == gotq[d].size());
            n++;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [47:0] rnd48();
        logic [47:0] v;
        case ($urandom_range(0, 5))
            0: v = 48'h800000000000;
            1: v = 48'h7FFFFFFFFFFF;
            2: v = 48'h7FF7FF7FF7FF;
            3: v = 48'h800800800800;
            default: v = 48'({$urandom(), $urandom()});
        endcase
        return v;
    endfunction

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (out_valid[d] !== 1'b0) begin errs++; $display("FAIL reset_out_valid dut%0d: got %b, required 0", d, out_valid[d]); end
            vectors++;
            if (in_ready[d] !== 1'b1) begin errs++; $display("FAIL reset_in_ready dut%0d: got %b, required 1", d, in_ready[d]); end
            vectors++;
            if (y_w[d] !== 48'h0 || ov_w[d] !== 4'h0) begin
                errs++; $display("FAIL reset_y_ovf dut%0d: got y=%h ovf=%b, required 0/0", d, y_w[d], ov_w[d]);
            end
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_add_sub();
        int n;
        bit ok;
        logic [51:0] g;
        logic [51:0] want [3];
        want[0] = {4'b0000, 48'd12};
        want[1] = {4'b0000, 48'hFFFFFFFFFFF9};
        want[2] = {4'b0001, 48'h7FFFFFFFFFFF};
        send(0, 2'd0, 48'd5, 48'd7);
        in_valid[0] = 1'b0;
        n = 1;
        while (!out_valid[0] && n < 10) begin @(posedge clock); #1; n++; end
        vectors++;
        if (n != 2) begin errs++; $display("FAIL add_latency: got %0d cycles, required 2", n); end
        send(0, 2'd1, 48'd3, 48'd10);
        send(0, 2'd1, 48'h800000000000, 48'd1);
        drain(0, ok);
        vectors++;
        if (!ok || gotq[0].size() != 3) begin errs++; $display("FAIL add_sub_count: got %0d results, required 3", gotq[0].size()); end
        for (int i = 0; i < 3 && gotq[0].size() > 0; i++) begin
            g = gotq[0].pop_front();
            vectors++;
            if (g !== want[i]) begin
                errs++; $display("FAIL add_sub_%0d: got y=%h ovf=%b, required y=%h ovf=%b", i, g[47:0], g[48], want[i][47:0], want[i][48]);
            end
        end
        expq[0].delete(); gotq[0].delete(); gotc[0].delete();
    endtask

    task automatic test_lanes();
        int n;
        bit ok;
        logic [51:0] g;
        send(1, 2'd0, {12'h7FF, 12'hFFF, 12'h001, 12'h000}, {12'h001, 12'h001, 12'h001, 12'h000});
        in_valid[1] = 1'b0;
        n = 1;
        while (!out_valid[1] && n < 10) begin @(posedge clock); #1; n++; end
        vectors++;
        if (n != 3) begin errs++; $display("FAIL lanes_latency: got %0d cycles, required 3", n); end
        drain(1, ok);
        vectors++;
        if (!ok || gotq[1].size() != 1) begin errs++; $display("FAIL lanes_count: got %0d results, required 1", gotq[1].size()); end
        if (gotq[1].size() > 0) begin
            g = gotq[1].pop_front();
            vectors++;
            if (g !== {4'b1000, 12'h800, 12'h000, 12'h002, 12'h000}) begin
                errs++; $display("FAIL lanes_add: got y=%h ovf=%b, required y=800000002000 ovf=1000", g[47:0], g[51:48]);
            end
        end
        expq[1].delete(); gotq[1].delete(); gotc[1].delete();
    endtask

    task automatic test_acc();
        bit ok;
        int c0;
        logic [47:0] want [6];
        want = '{48'd100, 48'd101, 48'd103, 48'd106, 48'd100, 48'd107};
        send(0, 2'd3, 48'd100, 48'd0);
        send(0, 2'd2, 48'd1, 48'd999);
        send(0, 2'd2, 48'd2, 48'd0);
        send(0, 2'd2, 48'd3, 48'd0);
        send(0, 2'd0, 48'd50, 48'd50);
        send(0, 2'd2, 48'd1, 48'd0);
        drain(0, ok);
        vectors++;
        if (!ok || gotq[0].size() != 6) begin errs++; $display("FAIL acc_count: got %0d results, required 6", gotq[0].size()); end
        c0 = (gotc[0].size() > 0) ? gotc[0][0] : 0;
        for (int i = 0; i < 6 && gotq[0].size() > 0; i++) begin
            vectors++;
            if (gotq[0][0][47:0] !== want[i] || gotq[0][0][48] !== 1'b0) begin
                errs++; $display("FAIL acc_seq_%0d: got y=%0d ovf=%b, required y=%0d ovf=0", i, gotq[0][0][47:0], gotq[0][0][48], want[i]);
            end
            vectors++;
            if (gotc[0][0] != c0 + i) begin
                errs++; $display("FAIL acc_back_to_back_%0d: got cycle %0d, required %0d", i, gotc[0][0], c0 + i);
            end
            void'(gotq[0].pop_front());
            void'(gotc[0].pop_front());
        end
        expq[0].delete(); gotq[0].delete(); gotc[0].delete();
    endtask

    task automatic test_stall();
        bit ok;
        logic [51:0] e, g;
        hold_bad[0] = 0;
        rdy_bad[0] = 0;
        ph = 0;
        rmode = 1;
        for (int i = 0; i < 8; i++) send(0, 2'd0, rnd48(), rnd48());
        drain(0, ok);
        vectors++;
        if (!ok || gotq[0].size() != 8) begin errs++; $display("FAIL stall_count: got %0d results, required 8", gotq[0].size()); end
        for (int i = 0; expq[0].size() > 0 && gotq[0].size() > 0; i++) begin
            e = expq[0].pop_front();
            g = gotq[0].pop_front();
            vectors++;
            if (g !== e) begin
                errs++; $display("FAIL stall_beat_%0d: got y=%h ovf=%b, required y=%h ovf=%b", i, g[47:0], g[48], e[47:0], e[48]);
            end
        end
        vectors++;
        if (hold_bad[0] != 0) begin errs++; $display("FAIL stall_hold: got %0d unstable cycles, required 0", hold_bad[0]); end
        vectors++;
        if (rdy_bad[0] != 0) begin errs++; $display("FAIL stall_in_ready: got %0d wrong cycles, required 0", rdy_bad[0]); end
        gotc[0].delete();
    endtask

    task automatic test_random();
        bit ok;
        logic [51:0] e, g;
        for (int d = 0; d < 2; d++) begin
            hold_bad[d] = 0;
            rdy_bad[d] = 0;
            rmode = 2;
            for (int i = 0; i < 60; i++) begin
                send(d, 2'($urandom_range(0, 3)), rnd48(), rnd48());
                if ($urandom_range(0, 3) == 0) begin
                    in_valid[d] = 1'b0;
                    @(posedge clock);
                    #1;
                end
            end
            drain(d, ok);
            vectors++;
            if (!ok || gotq[d].size() != 60) begin errs++; $display("FAIL random_count dut%0d: got %0d results, required 60", d, gotq[d].size()); end
            for (int i = 0; expq[d].size() > 0 && gotq[d].size() > 0; i++) begin
                e = expq[d].pop_front();
                g = gotq[d].pop_front();
                vectors++;
                if (g !== e) begin
                    errs++; $display("FAIL random_beat dut%0d #%0d: got y=%h ovf=%b, required y=%h ovf=%b", d, i, g[47:0], g[51:48], e[47:0], e[51:48]);
                end
            end
            vectors++;
            if (hold_bad[d] != 0 || rdy_bad[d] != 0) begin
                errs++; $display("FAIL random_handshake dut%0d: got hold=%0d ready=%0d bad cycles, required 0/0", d, hold_bad[d], rdy_bad[d]);
            end
            gotc[d].delete();
        end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        out_ready[0] = 1'b0;
        send(0, 2'd3, 48'd77, 48'd0);
        send(0, 2'd0, 48'd1, 48'd2);
        in_valid[0] = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if (out_valid[0] !== 1'b1) begin errs++; $display("FAIL midreset_inflight: got out_valid=%b, required 1", out_valid[0]); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid[0] !== 1'b0 || y_w[0] !== 48'h0 || ov_w[0] !== 4'h0) begin
            errs++; $display("FAIL midreset_clear: got out_valid=%b y=%h ovf=%b, required 0/0/0", out_valid[0], y_w[0], ov_w[0]);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (out_valid[0] !== 1'b0) begin errs++; $display("FAIL midreset_no_emit cycle %0d: got out_valid=%b, required 0", i, out_valid[0]); end
        end
        send(0, 2'd2, 48'd4, 48'd0);
        drain(0, ok);
        vectors++;
        if (!ok || gotq[0].size() != 1 || gotq[0][0] !== {4'b0000, 48'd4}) begin
            errs++; $display("FAIL midreset_acc_cleared: got %0d results, first y=%h, required 1 result y=4",
                             gotq[0].size(), (gotq[0].size() > 0) ? gotq[0][0][47:0] : 48'h0);
        end
        expq[0].delete(); gotq[0].delete(); gotc[0].delete();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            op[d] = 2'd0;
            a[d] = '0;
            b[d] = '0;
            acc_m[d] = '0;
            have_prev[d] = 1'b0;
            prev_stall[d] = 1'b0;
            prev_out[d] = '0;
        end
        test_reset();
        test_add_sub();
        test_lanes();
        test_acc();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
